trap_ctrl: RTL and testbench
============================

TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have parameter DRAIN_TIMEOUT, default 16, giving the maximum DRAIN cycles before forced commit (only used under TRAP_CTRL_TIMEOUT_EN).
REQ-002 SHALL have these ports, in this order:
- i_clk  in  1  sole clock; all state changes on its rising edge.
- i_rst  in  1  reset; asynchronous, active-high.
- i_ex_inst_addr, i_ex_illegal, i_ex_ebreak, i_ex_ecall, i_ex_ld_addr, i_ex_st_addr  in  1 each  synchronous exception flags from execute.
- i_int_tip  in  1  machine timer interrupt pending (level).
- i_mie, i_mtie  in  1 each  mstatus.MIE and mie.MTIE from the CSR file.
- i_mret  in  1  MRET decoded in execute.
- i_pc  in  `XLEN  PC of the instruction in execute.
- i_inst  in  32  instruction in execute.
- i_badaddr  in  `XLEN  faulting address for misaligned exceptions.
- i_pipe_idle  in  1  pipeline reports no in-flight memory or writeback.
- o_stall  out  1  freeze fetch/decode/execute.
- o_flush  out  1  kill younger instructions.
- o_trap_take  out  1  one-cycle pulse telling the CSR file to latch mepc/mcause/mtval and push mstatus.
- o_cause, o_epc, o_tval  out  `XLEN each  values latched by the CSR file on o_trap_take.
- o_redirect  out  1  one-cycle PC redirect pulse.
- o_redirect_sel  out  1  0 = target mtvec, 1 = target mepc.
- o_busy  out  1  FSM not in IDLE.
- o_drain_err  out  1  sticky drain-timeout flag.

Function
REQ-003 SHALL implement a four-state FSM: IDLE, DRAIN, COMMIT, REDIRECT.
REQ-004 In IDLE with any exception flag high, SHALL latch cause/epc/tval and go to DRAIN next cycle.
REQ-005 Exception priority, highest first: ebreak (cause 3, tval=i_pc), inst_addr (0, tval=i_badaddr), illegal (2, tval=i_inst zero-extended), ecall (11, tval=0), st_addr (6, tval=i_badaddr), ld_addr (4, tval=i_badaddr); epc=i_pc in all cases.
REQ-006 In IDLE with no exception, i_mret low, and i_int_tip&i_mie&i_mtie high, SHALL latch cause={1'b1, (`XLEN-4)'b0, 3'b111}, epc=i_pc+4 (wrapping modulo 2^`XLEN), tval=0, and go to DRAIN.
REQ-007 Exceptions beat interrupts in the same cycle; the interrupt stays pending and is re-evaluated on the next IDLE cycle.
REQ-008 In IDLE with i_mret high and no exception, SHALL go directly to REDIRECT with o_redirect_sel=1; a simultaneous interrupt is deferred.
REQ-009 DRAIN SHALL assert o_stall and o_flush and go to COMMIT in the cycle after i_pipe_idle is sampled high.
REQ-010 COMMIT SHALL assert o_trap_take and o_stall for exactly one cycle, then go to REDIRECT.
REQ-011 REDIRECT SHALL assert o_redirect and o_stall for exactly one cycle, with o_redirect_sel=0 after a trap, then return to IDLE.
REQ-012 All inputs except i_pipe_idle SHALL be ignored outside IDLE; trap latency from flag to o_redirect is at least 3 cycles.
REQ-013 o_cause/o_epc/o_tval SHALL hold their latched values from capture until the next capture.
REQ-014 o_busy SHALL be high exactly when the state is not IDLE.

Reset
REQ-015 On i_rst high, SHALL go to IDLE immediately and asynchronously, including mid-trap.
REQ-016 While i_rst is high, SHALL hold all outputs, the latched registers, the drain counter and o_drain_err at 0; no pending pulse survives reset.

Configuration
REQ-017 With macro TRAP_CTRL_TIMEOUT_EN defined, a drain counter SHALL clear on DRAIN entry and increment each DRAIN cycle; on reaching DRAIN_TIMEOUT-1 the FSM SHALL go to COMMIT and set o_drain_err, which clears only on reset.
REQ-018 Without TRAP_CTRL_TIMEOUT_EN, DRAIN SHALL wait indefinitely on i_pipe_idle, no counter SHALL exist, and o_drain_err SHALL be tied to 0.

Verification
REQ-019 Illegal: i_ex_illegal=1, i_pc=0x100, i_inst=0xFFFFFFFF, i_pipe_idle=1 -> DRAIN 1 cycle, o_trap_take with cause=2, epc=0x100, tval=0xFFFFFFFF, then o_redirect with sel=0.
REQ-020 Simultaneous: i_ex_ecall=1, i_ex_ld_addr=1 and an enabled timer interrupt -> cause=11; the interrupt is taken after return to IDLE with cause=0x80000007 and epc=i_pc+4.
REQ-021 MRET: i_mret=1 with i_int_tip=1 -> next cycle o_redirect=1, sel=1, no o_trap_take; the interrupt is taken on the following IDLE cycle.
REQ-022 Masking: i_int_tip=1, i_mie=0 for 20 cycles -> o_busy stays 0.
REQ-023 Timeout (macro on, DRAIN_TIMEOUT=4): exception with i_pipe_idle=0 -> o_trap_take after 4 DRAIN cycles and o_drain_err=1 until reset.
REQ-024 Reset mid-DRAIN: assert i_rst -> o_stall/o_flush drop 0 asynchronously; after release, IDLE and no o_trap_take.

Source files
------------

// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap sequencer (IDLE -> DRAIN -> COMMIT -> REDIRECT) for exceptions, timer interrupt and MRET.
// Optional drain watchdog is compiled in when TRAP_CTRL_TIMEOUT_EN is defined.
`ifndef XLEN
`define XLEN 32
`endif

module trap_ctrl #(
    parameter int DRAIN_TIMEOUT = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_ex_inst_addr,
    input  logic              i_ex_illegal,
    input  logic              i_ex_ebreak,
    input  logic              i_ex_ecall,
    input  logic              i_ex_ld_addr,
    input  logic              i_ex_st_addr,
    input  logic              i_int_tip,
    input  logic              i_mie,
    input  logic              i_mtie,
    input  logic              i_mret,
    input  logic [`XLEN-1:0]  i_pc,
    input  logic [31:0]       i_inst,
    input  logic [`XLEN-1:0]  i_badaddr,
    input  logic              i_pipe_idle,
    output logic              o_stall,
    output logic              o_flush,
    output logic              o_trap_take,
    output logic [`XLEN-1:0]  o_cause,
    output logic [`XLEN-1:0]  o_epc,
    output logic [`XLEN-1:0]  o_tval,
    output logic              o_redirect,
    output logic              o_redirect_sel,
    output logic              o_busy,
    output logic              o_drain_err
);

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        COMMIT,
        REDIRECT
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              capture;
    logic              sel_q;
    logic              sel_nxt;
    logic              any_ex;
    logic              int_req;
    logic              drain_done;
    logic [`XLEN-1:0]  cause_q;
    logic [`XLEN-1:0]  epc_q;
    logic [`XLEN-1:0]  tval_q;
    logic [`XLEN-1:0]  cause_nxt;
    logic [`XLEN-1:0]  epc_nxt;
    logic [`XLEN-1:0]  tval_nxt;

    assign any_ex  = i_ex_ebreak | i_ex_inst_addr | i_ex_illegal |
                     i_ex_ecall  | i_ex_st_addr   | i_ex_ld_addr;
    assign int_req = i_int_tip & i_mie & i_mtie;

    // Trap record selection; falls through to the timer interrupt when no exception is flagged.
    always_comb begin
        cause_nxt = '0;
        epc_nxt   = i_pc;
        tval_nxt  = '0;
        if (i_ex_ebreak) begin
            cause_nxt = `XLEN'(3);
            tval_nxt  = i_pc;
        end else if (i_ex_inst_addr) begin
            cause_nxt = `XLEN'(0);
            tval_nxt  = i_badaddr;
        end else if (i_ex_illegal) begin
            cause_nxt = `XLEN'(2);
            tval_nxt  = `XLEN'(i_inst);
        end else if (i_ex_ecall) begin
            cause_nxt = `XLEN'(11);
        end else if (i_ex_st_addr) begin
            cause_nxt = `XLEN'(6);
            tval_nxt  = i_badaddr;
        end else if (i_ex_ld_addr) begin
            cause_nxt = `XLEN'(4);
            tval_nxt  = i_badaddr;
        end else begin
            cause_nxt = {1'b1, {(`XLEN-4){1'b0}}, 3'b111};
            epc_nxt   = i_pc + `XLEN'(4);
        end
    end

`ifdef TRAP_CTRL_TIMEOUT_EN
    localparam int CNT_W = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;

    logic [CNT_W-1:0] drain_cnt;
    logic             drain_err_q;
    logic             drain_expired;

    assign drain_expired = (drain_cnt == CNT_W'(DRAIN_TIMEOUT - 1));
    assign drain_done    = i_pipe_idle | drain_expired;
    assign o_drain_err   = drain_err_q;

    // Counter sits at zero outside DRAIN so every DRAIN visit starts a fresh count.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            drain_cnt   <= '0;
            drain_err_q <= 1'b0;
        end else if (state == DRAIN) begin
            drain_cnt <= drain_cnt + CNT_W'(1);
            if (drain_expired && !i_pipe_idle) begin
                drain_err_q <= 1'b1;
            end
        end else begin
            drain_cnt <= '0;
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = |DRAIN_TIMEOUT;
    assign drain_done     = i_pipe_idle;
    assign o_drain_err    = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
            sel_q <= 1'b0;
        end else begin
            state <= state_nxt;
            sel_q <= sel_nxt;
        end
    end

    // Exceptions win over MRET and interrupts; MRET defers a coincident interrupt to the next IDLE cycle.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        sel_nxt   = sel_q;
        case (state)
            IDLE: begin
                if (any_ex) begin
                    capture   = 1'b1;
                    sel_nxt   = 1'b0;
                    state_nxt = DRAIN;
                end else if (i_mret) begin
                    sel_nxt   = 1'b1;
                    state_nxt = REDIRECT;
                end else if (int_req) begin
                    capture   = 1'b1;
                    sel_nxt   = 1'b0;
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_done) begin
                    state_nxt = COMMIT;
                end
            end
            COMMIT:   state_nxt = REDIRECT;
            REDIRECT: state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cause_q <= '0;
            epc_q   <= '0;
            tval_q  <= '0;
        end else if (capture) begin
            cause_q <= cause_nxt;
            epc_q   <= epc_nxt;
            tval_q  <= tval_nxt;
        end
    end

    assign o_stall        = (state != IDLE);
    assign o_busy         = (state != IDLE);
    assign o_flush        = (state == DRAIN);
    assign o_trap_take    = (state == COMMIT);
    assign o_redirect     = (state == REDIRECT);
    assign o_redirect_sel = sel_q;
    assign o_cause        = cause_q;
    assign o_epc          = epc_q;
    assign o_tval         = tval_q;

    // Structural invariants of the sequencer.
    a_take_then_redirect: assert property (@(posedge i_clk) disable iff (i_rst)
        o_trap_take |=> (o_redirect && !o_redirect_sel));
    a_flush_stalls: assert property (@(posedge i_clk) disable iff (i_rst)
        o_flush |-> o_stall);
    a_phase_onehot: assert property (@(posedge i_clk) disable iff (i_rst)
        $onehot0({o_flush, o_trap_take, o_redirect}));

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: scoreboard bench for trap_ctrl; expected trap records are queued at stimulus time and popped on o_trap_take.
`ifndef XLEN
`define XLEN 32
`endif

module tb_trap_ctrl;

    localparam int XL = `XLEN;
    typedef logic [XL-1:0] word_t;
    typedef struct {
        word_t cause;
        word_t epc;
        word_t tval;
    } trap_t;

    trap_t exp_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    word_t last_cause = '0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_ex_inst_addr, i_ex_illegal, i_ex_ebreak, i_ex_ecall, i_ex_ld_addr, i_ex_st_addr;
    logic        i_int_tip, i_mie, i_mtie, i_mret, i_pipe_idle;
    word_t       i_pc, i_badaddr;
    logic [31:0] i_inst;
    logic        o_stall, o_flush, o_trap_take, o_redirect, o_redirect_sel, o_busy, o_drain_err;
    word_t       o_cause, o_epc, o_tval;

    always #5 clk = ~clk;

    trap_ctrl #(.DRAIN_TIMEOUT(4)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_ex_inst_addr(i_ex_inst_addr), .i_ex_illegal(i_ex_illegal), .i_ex_ebreak(i_ex_ebreak),
        .i_ex_ecall(i_ex_ecall), .i_ex_ld_addr(i_ex_ld_addr), .i_ex_st_addr(i_ex_st_addr),
        .i_int_tip(i_int_tip), .i_mie(i_mie), .i_mtie(i_mtie), .i_mret(i_mret),
        .i_pc(i_pc), .i_inst(i_inst), .i_badaddr(i_badaddr), .i_pipe_idle(i_pipe_idle),
        .o_stall(o_stall), .o_flush(o_flush), .o_trap_take(o_trap_take),
        .o_cause(o_cause), .o_epc(o_epc), .o_tval(o_tval),
        .o_redirect(o_redirect), .o_redirect_sel(o_redirect_sel),
        .o_busy(o_busy), .o_drain_err(o_drain_err)
    );

    function automatic word_t int_cause();
        word_t c = '0;
        c[XL-1] = 1'b1;
        c[2:0]  = 3'b111;
        return c;
    endfunction

    // Flag order: {ebreak, inst_addr, illegal, ecall, st_addr, ld_addr}
    function automatic trap_t model_ex(logic [5:0] f, word_t pc, logic [31:0] inst, word_t bad);
        trap_t t;
        t.epc = pc; t.tval = '0; t.cause = '0;
        if (f[5])      begin t.cause = word_t'(3);  t.tval = pc; end
        else if (f[4]) begin t.cause = word_t'(0);  t.tval = bad; end
        else if (f[3]) begin t.cause = word_t'(2);  t.tval = word_t'(inst); end
        else if (f[2]) begin t.cause = word_t'(11); end
        else if (f[1]) begin t.cause = word_t'(6);  t.tval = bad; end
        else           begin t.cause = word_t'(4);  t.tval = bad; end
        return t;
    endfunction

    task automatic clear_inputs();
        {i_ex_ebreak, i_ex_inst_addr, i_ex_illegal, i_ex_ecall, i_ex_st_addr, i_ex_ld_addr} = 6'b0;
        i_int_tip = 1'b0; i_mie = 1'b0; i_mtie = 1'b0; i_mret = 1'b0;
        i_pc = '0; i_inst = '0; i_badaddr = '0; i_pipe_idle = 1'b1;
    endtask

    task automatic wait_take(input int max, output bit ok, output int cyc);
        ok = 1'b0; cyc = 0;
        while (!ok && cyc < max) begin
            @(negedge clk); cyc++;
            ok = (o_trap_take === 1'b1);
        end
    endtask

    task automatic wait_redirect(input int max, output bit ok, output int cyc);
        ok = 1'b0; cyc = 0;
        while (!ok && cyc < max) begin
            @(negedge clk); cyc++;
            ok = (o_redirect === 1'b1);
        end
    endtask

    task automatic test_reset();
        i_ex_illegal = 1'b1; i_mret = 1'b1;
        #3;
        n_cmp++;
        if ({o_stall, o_flush, o_trap_take, o_redirect, o_redirect_sel, o_busy, o_drain_err} !== 7'b0) begin
            n_bad++; $display("[TB] FAIL reset_ctrl: got %b, expected 0000000",
                {o_stall, o_flush, o_trap_take, o_redirect, o_redirect_sel, o_busy, o_drain_err});
        end
        @(negedge clk); @(negedge clk);
        n_cmp++;
        if (o_cause !== '0 || o_epc !== '0 || o_tval !== '0 || o_busy !== 1'b0) begin
            n_bad++; $display("[TB] FAIL reset_regs: got cause=%h epc=%h tval=%h busy=%b, expected all 0",
                o_cause, o_epc, o_tval, o_busy);
        end
        clear_inputs();
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (o_busy !== 1'b0) begin
            n_bad++; $display("[TB] FAIL reset_release_idle: got busy=%b, expected 0", o_busy);
        end
    endtask

    task automatic test_illegal();
        bit ok; int cyc; trap_t e;
        i_ex_illegal = 1'b1; i_pc = word_t'('h100); i_inst = 32'hFFFF_FFFF; i_pipe_idle = 1'b1;
        e.cause = word_t'(2); e.epc = word_t'('h100); e.tval = word_t'(32'hFFFF_FFFF);
        exp_q.push_back(e);
        @(negedge clk);
        i_ex_illegal = 1'b0;
        n_cmp++;
        if ({o_stall, o_flush, o_busy, o_trap_take} !== 4'b1110) begin
            n_bad++; $display("[TB] FAIL illegal_drain: got stall/flush/busy/take=%b, expected 1110",
                {o_stall, o_flush, o_busy, o_trap_take});
        end
        wait_take(8, ok, cyc);
        n_cmp++;
        if (!ok || cyc != 1) begin
            n_bad++; $display("[TB] FAIL illegal_latency: got take=%b after %0d cycles, expected take after 1", ok, cyc);
        end
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++; $display("[TB] FAIL illegal_trap: got empty scoreboard, expected one record");
        end else begin
            e = exp_q.pop_front();
            last_cause = e.cause;
            if (o_cause !== e.cause || o_epc !== e.epc || o_tval !== e.tval || o_flush !== 1'b0 || o_stall !== 1'b1) begin
                n_bad++; $display("[TB] FAIL illegal_trap: got cause=%h epc=%h tval=%h flush=%b stall=%b, expected %h %h %h 0 1",
                    o_cause, o_epc, o_tval, o_flush, o_stall, e.cause, e.epc, e.tval);
            end
        end
        @(negedge clk);
        n_cmp++;
        if ({o_redirect, o_redirect_sel, o_trap_take, o_stall} !== 4'b1001) begin
            n_bad++; $display("[TB] FAIL illegal_redirect: got redirect/sel/take/stall=%b, expected 1001",
                {o_redirect, o_redirect_sel, o_trap_take, o_stall});
        end
        @(negedge clk);
        n_cmp++;
        if (o_busy !== 1'b0 || o_cause !== last_cause) begin
            n_bad++; $display("[TB] FAIL illegal_return: got busy=%b cause=%h, expected 0 %h", o_busy, o_cause, last_cause);
        end
    endtask

    task automatic test_priority();
        logic [5:0] tbl [8] = '{6'b111111, 6'b011111, 6'b001111, 6'b000111,
                                6'b000011, 6'b000001, 6'b100000, 6'b010001};
        bit ok; int cyc; trap_t e;
        for (int i = 0; i < 8; i++) begin
            i_pc      = word_t'('h1000 + i * 'h10);
            i_inst    = $urandom;
            i_badaddr = word_t'($urandom);
            i_mret    = (i == 2);
            {i_ex_ebreak, i_ex_inst_addr, i_ex_illegal, i_ex_ecall, i_ex_st_addr, i_ex_ld_addr} = tbl[i];
            exp_q.push_back(model_ex(tbl[i], i_pc, i_inst, i_badaddr));
            @(negedge clk);
            clear_inputs();
            wait_take(8, ok, cyc);
            n_cmp++;
            if (!ok || exp_q.size() == 0) begin
                n_bad++; $display("[TB] FAIL prio_%0d_take: got take=%b queue=%0d, expected take with one record", i, ok, exp_q.size());
            end else begin
                e = exp_q.pop_front();
                last_cause = e.cause;
                if (o_cause !== e.cause || o_epc !== e.epc || o_tval !== e.tval) begin
                    n_bad++; $display("[TB] FAIL prio_%0d_trap: got cause=%h epc=%h tval=%h, expected %h %h %h",
                        i, o_cause, o_epc, o_tval, e.cause, e.epc, e.tval);
                end
            end
            wait_redirect(4, ok, cyc);
            n_cmp++;
            if (!ok || o_redirect_sel !== 1'b0) begin
                n_bad++; $display("[TB] FAIL prio_%0d_redirect: got redirect=%b sel=%b, expected 1 0", i, ok, o_redirect_sel);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_simultaneous();
        bit ok; int cyc; trap_t e;
        i_pc = word_t'('h200); i_badaddr = word_t'('h55);
        i_ex_ecall = 1'b1; i_ex_ld_addr = 1'b1;
        i_int_tip = 1'b1; i_mie = 1'b1; i_mtie = 1'b1;
        e.cause = word_t'(11); e.epc = word_t'('h200); e.tval = '0;
        exp_q.push_back(e);
        e.cause = int_cause(); e.epc = word_t'('h204); e.tval = '0;
        exp_q.push_back(e);
        @(negedge clk);
        i_ex_ecall = 1'b0; i_ex_ld_addr = 1'b0;
        for (int t = 0; t < 2; t++) begin
            wait_take(8, ok, cyc);
            n_cmp++;
            if (!ok || exp_q.size() == 0) begin
                n_bad++; $display("[TB] FAIL simul_%0d_take: got take=%b queue=%0d, expected take with one record", t, ok, exp_q.size());
            end else begin
                e = exp_q.pop_front();
                last_cause = e.cause;
                if (o_cause !== e.cause || o_epc !== e.epc || o_tval !== e.tval) begin
                    n_bad++; $display("[TB] FAIL simul_%0d_trap: got cause=%h epc=%h tval=%h, expected %h %h %h",
                        t, o_cause, o_epc, o_tval, e.cause, e.epc, e.tval);
                end
            end
            if (t == 1) begin
                i_int_tip = 1'b0; i_mie = 1'b0; i_mtie = 1'b0;
            end
            wait_redirect(4, ok, cyc);
            n_cmp++;
            if (!ok || o_redirect_sel !== 1'b0) begin
                n_bad++; $display("[TB] FAIL simul_%0d_redirect: got redirect=%b sel=%b, expected 1 0", t, ok, o_redirect_sel);
            end
        end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_mret();
        bit ok; int cyc; trap_t e;
        i_pc = word_t'('h300); i_mret = 1'b1;
        i_int_tip = 1'b1; i_mie = 1'b1; i_mtie = 1'b1;
        @(negedge clk);
        i_mret = 1'b0;
        n_cmp++;
        if ({o_redirect, o_redirect_sel, o_trap_take} !== 3'b110 || o_cause !== last_cause) begin
            n_bad++; $display("[TB] FAIL mret_redirect: got redirect/sel/take=%b cause=%h, expected 110 %h",
                {o_redirect, o_redirect_sel, o_trap_take}, o_cause, last_cause);
        end
        @(negedge clk);
        n_cmp++;
        if (o_busy !== 1'b0) begin
            n_bad++; $display("[TB] FAIL mret_idle: got busy=%b, expected 0", o_busy);
        end
        e.cause = int_cause(); e.epc = word_t'('h304); e.tval = '0;
        exp_q.push_back(e);
        wait_take(8, ok, cyc);
        i_int_tip = 1'b0;
        n_cmp++;
        if (!ok || cyc != 2 || exp_q.size() == 0) begin
            n_bad++; $display("[TB] FAIL mret_int_take: got take=%b after %0d cycles, expected take after 2", ok, cyc);
        end else begin
            e = exp_q.pop_front();
            last_cause = e.cause;
            if (o_cause !== e.cause || o_epc !== e.epc || o_tval !== e.tval) begin
                n_bad++; $display("[TB] FAIL mret_int_trap: got cause=%h epc=%h tval=%h, expected %h %h %h",
                    o_cause, o_epc, o_tval, e.cause, e.epc, e.tval);
            end
        end
        wait_redirect(4, ok, cyc);
        n_cmp++;
        if (!ok || o_redirect_sel !== 1'b0) begin
            n_bad++; $display("[TB] FAIL mret_int_redirect: got redirect=%b sel=%b, expected 1 0", ok, o_redirect_sel);
        end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_masking();
        i_int_tip = 1'b1; i_mie = 1'b0; i_mtie = 1'b1; i_pc = word_t'('h600);
        for (int k = 0; k < 25; k++) begin
            if (k == 20) begin
                i_mie = 1'b1; i_mtie = 1'b0;
            end
            @(negedge clk);
            n_cmp++;
            if (o_busy !== 1'b0 || o_trap_take !== 1'b0) begin
                n_bad++; $display("[TB] FAIL mask_%0d: got busy=%b take=%b, expected 0 0", k, o_busy, o_trap_take);
            end
        end
        clear_inputs();
    endtask

    task automatic test_timeout();
        bit ok; int cyc; trap_t e;
        i_ex_illegal = 1'b1; i_pc = word_t'('h400); i_inst = 32'h0000_0013; i_pipe_idle = 1'b0;
        e.cause = word_t'(2); e.epc = word_t'('h400); e.tval = word_t'(32'h13);
        exp_q.push_back(e);
`ifdef TRAP_CTRL_TIMEOUT_EN
        begin
            int drains = 0;
            ok = 1'b0;
            for (int k = 0; k < 20 && !ok; k++) begin
                @(negedge clk);
                i_ex_illegal = 1'b0;
                if (o_trap_take === 1'b1) ok = 1'b1;
                else if (o_flush === 1'b1) drains++;
            end
            n_cmp++;
            if (!ok || drains != 4 || o_drain_err !== 1'b1) begin
                n_bad++; $display("[TB] FAIL timeout_commit: got take=%b drains=%0d err=%b, expected 1 4 1", ok, drains, o_drain_err);
            end
        end
`else
        begin
            bit held = 1'b1;
            for (int k = 0; k < 30; k++) begin
                @(negedge clk);
                i_ex_illegal = 1'b0;
                if (o_flush !== 1'b1 || o_trap_take !== 1'b0 || o_drain_err !== 1'b0) held = 1'b0;
            end
            n_cmp++;
            if (!held) begin
                n_bad++; $display("[TB] FAIL drain_wait: got early exit or drain_err during 30 idle-low cycles, expected steady DRAIN");
            end
            i_pipe_idle = 1'b1;
            wait_take(4, ok, cyc);
            n_cmp++;
            if (!ok || cyc != 1) begin
                n_bad++; $display("[TB] FAIL drain_release: got take=%b after %0d cycles, expected take after 1", ok, cyc);
            end
        end
`endif
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++; $display("[TB] FAIL timeout_trap: got empty scoreboard, expected one record");
        end else begin
            e = exp_q.pop_front();
            last_cause = e.cause;
            if (o_cause !== e.cause || o_epc !== e.epc || o_tval !== e.tval) begin
                n_bad++; $display("[TB] FAIL timeout_trap: got cause=%h epc=%h tval=%h, expected %h %h %h",
                    o_cause, o_epc, o_tval, e.cause, e.epc, e.tval);
            end
        end
        i_pipe_idle = 1'b1;
        wait_redirect(4, ok, cyc);
        for (int k = 0; k < 6; k++) @(negedge clk);
`ifdef TRAP_CTRL_TIMEOUT_EN
        n_cmp++;
        if (o_drain_err !== 1'b1 || o_busy !== 1'b0) begin
            n_bad++; $display("[TB] FAIL timeout_sticky: got err=%b busy=%b, expected 1 0", o_drain_err, o_busy);
        end
`else
        n_cmp++;
        if (o_drain_err !== 1'b0 || o_busy !== 1'b0) begin
            n_bad++; $display("[TB] FAIL drain_err_tied: got err=%b busy=%b, expected 0 0", o_drain_err, o_busy);
        end
`endif
        clear_inputs();
    endtask

    task automatic test_reset_mid_drain();
        bit quiet = 1'b1;
        i_ex_ecall = 1'b1; i_pc = word_t'('h500); i_pipe_idle = 1'b0;
        @(negedge clk);
        i_ex_ecall = 1'b0;
        n_cmp++;
        if (o_flush !== 1'b1 || o_stall !== 1'b1) begin
            n_bad++; $display("[TB] FAIL rst_mid_pre: got flush=%b stall=%b, expected 1 1", o_flush, o_stall);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({o_stall, o_flush, o_busy, o_trap_take, o_redirect, o_redirect_sel, o_drain_err} !== 7'b0) begin
            n_bad++; $display("[TB] FAIL rst_mid_async: got %b, expected 0000000",
                {o_stall, o_flush, o_busy, o_trap_take, o_redirect, o_redirect_sel, o_drain_err});
        end
        n_cmp++;
        if (o_cause !== '0 || o_epc !== '0 || o_tval !== '0) begin
            n_bad++; $display("[TB] FAIL rst_mid_regs: got cause=%h epc=%h tval=%h, expected 0 0 0", o_cause, o_epc, o_tval);
        end
        @(negedge clk);
        i_pipe_idle = 1'b1;
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (o_trap_take !== 1'b0 || o_busy !== 1'b0) quiet = 1'b0;
        end
        n_cmp++;
        if (!quiet) begin
            n_bad++; $display("[TB] FAIL rst_mid_after: got trap activity after reset release, expected idle");
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_illegal();
        test_priority();
        test_simultaneous();
        test_mret();
        test_masking();
        test_timeout();
        test_reset_mid_drain();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++; $display("[TB] FAIL scoreboard_drained: got %0d leftover records, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no completion by 100000ns, expected earlier finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
